acc_seq_ctrl: RTL and testbench

Sequencing controller for the gate-level 4-bit accumulator datapath (input register → ripple adder → sum register).
- Accepts a command giving a word count N.
- Clears the datapath, then streams N operand words into it under a valid/ready handshake.
- Tracks words in flight through the datapath pipeline and captures the final sum with a sticky overflow flag.
- Presents the result on a valid/ready result port.

---
 rtl/acc_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_acc_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_seq_ctrl.sv
// Sequencing controller for the 4-bit accumulator datapath: clears it, streams
// N operand words under valid/ready, drains the pipeline and returns the sum.
module acc_seq_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             dp_clr,
  output logic             dp_en,
  output logic [WIDTH-1:0] dp_data,
  input  logic [WIDTH-1:0] dp_sum,
  input  logic             dp_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [PIPE_LAT-1:0] v_q, v_d;
  logic                ovf_q, ovf_d;
  logic [WIDTH-1:0]    res_data_q, res_data_d;
  logic                res_ovf_q, res_ovf_d;

  logic             accept;
  logic             cmd_ready_int, in_ready_int, dp_clr_int, dp_en_int;
  logic             res_valid_int;
  logic [WIDTH-1:0] dp_data_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      v_q        <= '0;
      ovf_q      <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      v_q        <= v_d;
      ovf_q      <= ovf_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  // Next state, in-flight tracking and handshake outputs.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    accept        = (state_q == S_FEED) && in_valid;
    v_d           = {v_q[PIPE_LAT-2:0], accept};
    // v[PIPE_LAT-2] marks the cycle whose adder operands belong to a committed word
    ovf_d         = ovf_q | (v_q[PIPE_LAT-2] & dp_carry);
    res_data_d    = res_data_q;
    res_ovf_d     = res_ovf_q;
    cmd_ready_int = 1'b0;
    in_ready_int  = 1'b0;
    dp_clr_int    = 1'b0;
    dp_en_int     = 1'b0;
    dp_data_int   = '0;
    res_valid_int = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_int = 1'b1;
        if (cmd_valid) begin
          rem_d   = cmd_len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        dp_clr_int = 1'b1;
        ovf_d      = 1'b0;
        v_d        = '0;
        state_d    = (rem_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        in_ready_int = 1'b1;
        if (accept) begin
          dp_en_int   = 1'b1;
          dp_data_int = in_data;
          rem_d       = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (v_q == '0) begin
          res_data_d = dp_sum;
          res_ovf_d  = ovf_q;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        res_valid_int = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Everything reads zero while reset is held, even before the reset edge.
  assign cmd_ready = cmd_ready_int & ~rst;
  assign in_ready  = in_ready_int & ~rst;
  assign dp_clr    = dp_clr_int & ~rst;
  assign dp_en     = dp_en_int & ~rst;
  assign dp_data   = rst ? '0 : dp_data_int;
  assign res_valid = res_valid_int & ~rst;
  assign res_data  = rst ? '0 : res_data_q;
  assign res_ovf   = res_ovf_q & ~rst;
  assign busy      = (state_q != S_IDLE) & ~rst;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl with a behavioural 2-stage accumulator
// datapath and a queue of expected results.
module tb_acc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, dp_rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_len;
  logic       in_valid, in_ready;
  logic [3:0] in_data;
  logic       dp_clr, dp_en;
  logic [3:0] dp_data, dp_sum;
  logic       dp_carry;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic       res_ovf, busy;

  acc_seq_ctrl #(.WIDTH(4), .CNT_W(4), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_clr(dp_clr), .dp_en(dp_en), .dp_data(dp_data),
    .dp_sum(dp_sum), .dp_carry(dp_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath: input register, ripple adder, sum register.
  logic [3:0] in_reg;
  logic       a_v;
  logic [4:0] add_full;
  assign add_full = {1'b0, in_reg} + {1'b0, dp_sum};
  assign dp_carry = add_full[4];
  always @(posedge clk) begin
    if (dp_rst) begin
      in_reg <= 4'h0; a_v <= 1'b0; dp_sum <= 4'h0;
    end else begin
      if (dp_en) in_reg <= dp_data;
      a_v <= dp_en;
      if (dp_clr) dp_sum <= 4'h0;
      else if (a_v) dp_sum <= add_full[3:0];
    end
  end

  int n_pass = 0, n_chk = 0;
  int cyc = 0, hs_cyc = 0, last_acc = 0;
  int clr_cnt = 0, clr_cyc = 0, first_en = -1, rdy_seen = 0;
  logic [3:0] words[$];
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    #1;
    if (dp_clr) begin clr_cnt++; clr_cyc = cyc; end
    if (dp_en && first_en < 0) first_en = cyc;
    if (in_ready) rdy_seen++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic outs_zero(input string tag);
    check(tag, 32'({cmd_ready, in_ready, dp_clr, dp_en, dp_data, res_valid,
                    res_data, res_ovf, busy}), 32'h0);
  endtask

  // Issue a command, push its expected result, and step through CLEAR.
  task automatic start_cmd(input logic [3:0] len, input bit push);
    logic [3:0] s;
    logic       o;
    logic [4:0] t;
    int g;
    s = 4'h0; o = 1'b0;
    foreach (words[i]) begin
      t = {1'b0, s} + {1'b0, words[i]};
      s = t[3:0];
      o = o | t[4];
    end
    if (push) exp_q.push_back({o, s});
    cmd_valid = 1'b1; cmd_len = len;
    g = 0;
    while (!cmd_ready && g < 20) begin step(); g++; end
    check("cmd_ready_at_cmd", 32'(cmd_ready), 32'h1);
    hs_cyc = cyc; clr_cnt = 0; first_en = -1; rdy_seen = 0;
    step();
    cmd_valid = 1'b0; cmd_len = 4'h0;
    check("dp_clr_in_clear", 32'(dp_clr), 32'h1);
    step();
  endtask

  // Drive words per valid pattern (bit i = cycle i); invalid cycles carry junk data.
  task automatic feed(input logic [15:0] pat, input int plen);
    int idx;
    bit b;
    logic [3:0] w;
    idx = 0;
    for (int i = 0; i < plen; i++) begin
      b = pat[i];
      w = b ? words[idx] : 4'hA;
      in_valid = b; in_data = w;
      #1;
      check("in_ready_feed", 32'(in_ready), 32'h1);
      check("dp_en_feed", 32'(dp_en), 32'(b));
      check("dp_data_feed", 32'(dp_data), b ? 32'(w) : 32'h0);
      if (b) begin last_acc = cyc; idx++; end
      step();
    end
    in_valid = 1'b0; in_data = 4'h0;
  endtask

  // Wait (bounded) for res_valid, compare latency and the queued expectation.
  task automatic wait_result(input string tag, input int from, input int lat);
    int g;
    logic [4:0] e;
    g = 0;
    while (!res_valid && g < 30) begin
      check({tag, "_no_dp_en"}, 32'(dp_en), 32'h0);
      step(); g++;
    end
    check({tag, "_res_valid"}, 32'(res_valid), 32'h1);
    check({tag, "_latency"}, 32'(cyc - from), 32'(lat));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 32'h0, 32'h1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_res_data"}, 32'(res_data), 32'(e[3:0]));
      check({tag, "_res_ovf"}, 32'(res_ovf), 32'(e[4]));
    end
    if (res_ready) step();
  endtask

  initial begin
    rst = 1'b1; dp_rst = 1'b1;
    cmd_valid = 1'b0; cmd_len = 4'h0; in_valid = 1'b0; in_data = 4'h0;
    res_ready = 1'b1;
    step(); step();
    outs_zero("reset_outputs");
    rst = 1'b0; dp_rst = 1'b0;
    step();
    check("idle_cmd_ready", 32'(cmd_ready), 32'h1);
    check("idle_busy", 32'(busy), 32'h0);

    // 1: 1+2+3 back-to-back
    words = '{4'd1, 4'd2, 4'd3};
    start_cmd(4'd3, 1'b1);
    feed(16'b111, 3);
    wait_result("t1", last_acc, 4);
    check("t1_clr_pulses", 32'(clr_cnt), 32'h1);
    check("t1_clr_before_en", 32'(clr_cyc < first_en), 32'h1);
    check("t1_back_to_idle", 32'(busy), 32'h0);

    // 2: 15+3 wraps with overflow
    words = '{4'd15, 4'd3};
    start_cmd(4'd2, 1'b1);
    feed(16'b11, 2);
    wait_result("t2", last_acc, 4);

    // 3: gapped valid 1,0,0,1,1,0,1
    words = '{4'd5, 4'd5, 4'd5, 4'd5};
    start_cmd(4'd4, 1'b1);
    feed(16'b1011001, 7);
    wait_result("t3", last_acc, 4);

    // 4: zero-length command
    words = {};
    start_cmd(4'd0, 1'b1);
    wait_result("t4", hs_cyc, 3);
    check("t4_in_ready_never", 32'(rdy_seen), 32'h0);

    // 5: result stall with a pending command
    words = '{4'd9};
    res_ready = 1'b0;
    start_cmd(4'd1, 1'b1);
    feed(16'b1, 1);
    wait_result("t5", last_acc, 4);
    cmd_valid = 1'b1; cmd_len = 4'd5;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 32'(res_valid), 32'h1);
      check("t5_hold_data", 32'(res_data), 32'h9);
      check("t5_no_cmd_ready", 32'(cmd_ready), 32'h0);
      check("t5_no_in_ready", 32'(in_ready), 32'h0);
      step();
    end
    res_ready = 1'b1;
    #1;
    check("t5_done_cmd_ready", 32'(cmd_ready), 32'h0);
    step();
    cmd_valid = 1'b0; cmd_len = 4'h0;
    #1;
    check("t5_next_cmd_ready", 32'(cmd_ready), 32'h1);
    check("t5_next_busy", 32'(busy), 32'h0);
    step();
    check("t5_no_overlap_accept", 32'(busy), 32'h0);

    // 6: reset in FEED after 2 of 4 words, then a fresh command
    words = '{4'd1, 4'd2, 4'd3, 4'd4};
    start_cmd(4'd4, 1'b0);
    feed(16'b11, 2);
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd3;
    step();
    outs_zero("t6_rst_outputs");
    rst = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    step();
    check("t6_after_rst_busy", 32'(busy), 32'h0);
    check("t6_after_rst_ready", 32'(cmd_ready), 32'h1);
    check("t6_no_result", 32'(res_valid), 32'h0);
    words = '{4'd7};
    start_cmd(4'd1, 1'b1);
    feed(16'b1, 1);
    wait_result("t6", last_acc, 4);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
